// File: rtl/zap_prefetch_buffer.sv
// First-word-fall-through prefetch buffer between the I-cache and the 16-bit decoder.
// Stops fetching after an instruction abort until a clear arrives.
module zap_prefetch_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_clear,
    input  logic                     i_wr_valid,
    input  logic [31:0]              i_wr_instruction,
    input  logic [31:0]              i_wr_pc,
    input  logic [1:0]               i_wr_taken,
    input  logic                     i_wr_iabort,
    output logic                     o_wr_ready,
    input  logic                     i_stall,
    output logic [31:0]              o_instruction,
    output logic                     o_instruction_valid,
    output logic [31:0]              o_pc_ff,
    output logic [31:0]              o_pc_plus_8_ff,
    output logic [1:0]               o_taken,
    output logic                     o_iabort,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] insn;
        logic [31:0] pc;
        logic [1:0]  taken;
        logic        iabort;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [AW:0]   level_q, level_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic          abort_hold_q, abort_hold_d;
    logic          push, pop;

    // Full buffer never accepts, even when the head pops in the same cycle.
    always_comb begin
        o_instruction_valid = (level_q != '0);
        o_wr_ready          = (level_q < LVL_FULL) && !abort_hold_q;
        push                = i_wr_valid && o_wr_ready;
        pop                 = o_instruction_valid && !i_stall;
    end

    always_comb begin
        level_d      = level_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        abort_hold_d = abort_hold_q;
        if (i_clear) begin
            level_d      = '0;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            abort_hold_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
            if (push && i_wr_iabort) abort_hold_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            level_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            abort_hold_q <= 1'b0;
        end else begin
            level_q      <= level_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            abort_hold_q <= abort_hold_d;
        end
    end

    // Storage is not reset; empty-buffer output gating hides stale words.
    always_ff @(posedge i_clk) begin
        if (push && !i_clear)
            mem_q[wr_ptr_q] <= '{insn: i_wr_instruction, pc: i_wr_pc,
                                 taken: i_wr_taken, iabort: i_wr_iabort};
    end

    always_comb begin
        head           = mem_q[rd_ptr_q];
        o_instruction  = o_instruction_valid ? head.insn   : 32'h0;
        o_pc_ff        = o_instruction_valid ? head.pc     : 32'h0;
        o_taken        = o_instruction_valid ? head.taken  : 2'b00;
        o_iabort       = o_instruction_valid ? head.iabort : 1'b0;
        o_pc_plus_8_ff = o_pc_ff + 32'd8;
        o_level        = level_q;
    end

endmodule
